reg_array16: RTL and testbench

//  16-entry x 32-bit register storage for the register bank. Drives q0..q15 straight

---
 rtl/reg_array16_if.sv | 23 ++
 rtl/reg_array16.sv | 98 +++++++++
 tb/tb_reg_array16.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_array16_if.sv
// Write/clear port bundle of the 16-entry register array.
// Handshake: a write transfers on a rising edge where wr_valid && wr_ready; the source
// holds wr_valid/wr_addr/wr_data stable until then, and wr_ready never depends on wr_valid.
interface reg_array16_if #(
  parameter int WIDTH = 32
) ();
  logic             wr_valid;
  logic             wr_ready;
  logic [3:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             clr_req;
  logic             busy;

  modport master (
    output wr_valid, wr_addr, wr_data, clr_req,
    input  wr_ready, busy
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, clr_req,
    output wr_ready, busy
  );
endinterface

// File: rtl/reg_array16.sv
// 16 x WIDTH register storage feeding the read muxes directly; one handshaked write port
// and a sequencer that zeroes one entry per cycle when a clear is requested.
module reg_array16 #(
  parameter int WIDTH   = 32,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  reg_array16_if.slave     wr,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [WIDTH-1:0] q4,
  output logic [WIDTH-1:0] q5,
  output logic [WIDTH-1:0] q6,
  output logic [WIDTH-1:0] q7,
  output logic [WIDTH-1:0] q8,
  output logic [WIDTH-1:0] q9,
  output logic [WIDTH-1:0] q10,
  output logic [WIDTH-1:0] q11,
  output logic [WIDTH-1:0] q12,
  output logic [WIDTH-1:0] q13,
  output logic [WIDTH-1:0] q14,
  output logic [WIDTH-1:0] q15,
  output logic             dbg_state
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [3:0]       clr_ptr, clr_ptr_nxt;
  logic [WIDTH-1:0] mem [16];
  logic             ready_int, busy_int;
  logic             wr_fire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      clr_ptr <= 4'd0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
      // Writes only fire in IDLE and clearing only happens in CLEAR, so they never collide.
      if (wr_fire && !(ZERO_R0 && wr.wr_addr == 4'd0)) mem[wr.wr_addr] <= wr.wr_data;
      if (state == CLEAR) mem[clr_ptr] <= '0;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    ready_int   = 1'b0;
    busy_int    = 1'b0;
    case (state)
      IDLE: begin
        ready_int = 1'b1;
        if (wr.clr_req) begin
          state_nxt   = CLEAR;
          clr_ptr_nxt = 4'd0;
        end
      end
      CLEAR: begin
        busy_int    = 1'b1;
        clr_ptr_nxt = clr_ptr + 4'd1;
        if (clr_ptr == 4'd15) begin
          state_nxt   = IDLE;
          clr_ptr_nxt = 4'd0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_fire     = wr.wr_valid && ready_int;
  assign wr.wr_ready = ready_int;
  assign wr.busy     = busy_int;
  assign dbg_state   = (state == CLEAR);

  assign q0  = ZERO_R0 ? '0 : mem[0];
  assign q1  = mem[1];
  assign q2  = mem[2];
  assign q3  = mem[3];
  assign q4  = mem[4];
  assign q5  = mem[5];
  assign q6  = mem[6];
  assign q7  = mem[7];
  assign q8  = mem[8];
  assign q9  = mem[9];
  assign q10 = mem[10];
  assign q11 = mem[11];
  assign q12 = mem[12];
  assign q13 = mem[13];
  assign q14 = mem[14];
  assign q15 = mem[15];

endmodule

// File: tb/tb_reg_array16.sv
// Directed bench for reg_array16: a driver pushes expected values, a negedge monitor
// pops and compares them against the array contents and status outputs.
module tb_reg_array16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_array16_if #(.WIDTH(32)) bus ();
  reg_array16_if #(.WIDTH(32)) bus_z ();

  logic [31:0] q  [16];
  logic [31:0] qz [16];
  logic        st, stz;

  reg_array16 #(.WIDTH(32), .ZERO_R0(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .wr(bus.slave),
    .q0(q[0]), .q1(q[1]), .q2(q[2]), .q3(q[3]), .q4(q[4]), .q5(q[5]), .q6(q[6]), .q7(q[7]),
    .q8(q[8]), .q9(q[9]), .q10(q[10]), .q11(q[11]), .q12(q[12]), .q13(q[13]), .q14(q[14]),
    .q15(q[15]), .dbg_state(st)
  );

  reg_array16 #(.WIDTH(32), .ZERO_R0(1'b1)) dut_z (
    .clk(clk), .rst_n(rst_n), .wr(bus_z.slave),
    .q0(qz[0]), .q1(qz[1]), .q2(qz[2]), .q3(qz[3]), .q4(qz[4]), .q5(qz[5]), .q6(qz[6]), .q7(qz[7]),
    .q8(qz[8]), .q9(qz[9]), .q10(qz[10]), .q11(qz[11]), .q12(qz[12]), .q13(qz[13]), .q14(qz[14]),
    .q15(qz[15]), .dbg_state(stz)
  );

  // Scoreboard: selector 0..15 = q index, 16 ready, 17 busy, 18 z.q0, 19 z.ready, 20 z.q1
  logic [31:0] exp_q [$];
  int          sel_q [$];
  string       name_q [$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] model [16];

  function automatic logic [31:0] dut_val(input int sel);
    if (sel < 16) return q[sel];
    case (sel)
      16:      return {31'b0, bus.wr_ready};
      17:      return {31'b0, bus.busy};
      18:      return qz[0];
      19:      return {31'b0, bus_z.wr_ready};
      20:      return qz[1];
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [31:0] e;
      int          s;
      string       n;
      e = exp_q.pop_front();
      s = sel_q.pop_front();
      n = name_q.pop_front();
      total++;
      if (dut_val(s) !== e) begin
        bad++;
        $display("FAIL %s: got %h expected %h", n, dut_val(s), e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int sel, input logic [31:0] v, input string n);
    exp_q.push_back(v);
    sel_q.push_back(sel);
    name_q.push_back(n);
  endtask

  task automatic chk_all(input string n);
    for (int i = 0; i < 16; i++) chk(i, model[i], $sformatf("%s q%0d", n, i));
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    step();
    bus.wr_valid = 1'b0;
    model[a]     = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.wr_valid = 1'b0; bus.wr_addr = 4'd0; bus.wr_data = 32'h0; bus.clr_req = 1'b0;
    bus_z.wr_valid = 1'b0; bus_z.wr_addr = 4'd0; bus_z.wr_data = 32'h0; bus_z.clr_req = 1'b0;
    clear_model();
    step();
    step();
    rst_n = 1'b1;
    chk_all("reset0");
    chk(16, 32'd1, "reset0 ready");
    chk(17, 32'd0, "reset0 busy");
    step();

    // Reset after nonzero writes
    do_write(4'd1, 32'h1111_1111);
    do_write(4'd2, 32'h2222_2222);
    chk(1, 32'h1111_1111, "pre-reset q1");
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    clear_model();
    chk_all("reset");
    chk(16, 32'd1, "reset ready");
    chk(17, 32'd0, "reset busy");
    step();

    // Write latency and isolation
    do_write(4'd5, 32'hDEAD_BEEF);
    chk_all("wr5");
    step();
    chk(5, 32'hDEAD_BEEF, "wr5 hold");

    // Full clear sequence
    for (int i = 0; i < 16; i++) do_write(4'(i), 32'h100 + 32'(i));
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    chk(17, 32'd1, "clr busy k0");
    chk(0, 32'h100, "clr q0 k0");
    for (int k = 1; k <= 16; k++) begin
      step();
      model[k-1] = 32'h0;
      chk(17, (k < 16) ? 32'd1 : 32'd0, $sformatf("clr busy k%0d", k));
      if (k == 3) begin
        chk(3, 32'h103, "clr q3 k3");
        chk_all("clr k3");
      end
    end
    chk_all("clr done");
    chk(16, 32'd1, "clr done ready");

    // Write held during clear
    do_write(4'd9, 32'h77);
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 3) begin
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 4'd9;
        bus.wr_data  = 32'h55;
      end
      step();
      model[k-1] = 32'h0;
      if (k >= 3 && k <= 6) begin
        chk(16, 32'd0, $sformatf("wrclr ready k%0d", k));
        chk(9, 32'h77, $sformatf("wrclr q9 k%0d", k));
      end
    end
    chk(9, 32'h0, "wrclr q9 cleared");
    chk(16, 32'd1, "wrclr ready idle");
    step();
    bus.wr_valid = 1'b0;
    model[9] = 32'h55;
    chk(9, 32'h55, "wrclr q9 accepted");
    chk_all("wrclr after");

    // Clear request and write on the same edge
    bus.clr_req  = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 4'd15;
    bus.wr_data  = 32'hAA;
    step();
    bus.clr_req  = 1'b0;
    bus.wr_valid = 1'b0;
    chk(15, 32'hAA, "simul q15");
    chk(17, 32'd1, "simul busy");
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 15) begin
        chk(15, 32'hAA, "simul q15 k15");
        chk(17, 32'd1, "simul busy k15");
      end
    end
    clear_model();
    chk(15, 32'h0, "simul q15 k16");
    chk(17, 32'd0, "simul busy k16");

    // Reset in the middle of a clear
    do_write(4'd3, 32'h33);
    do_write(4'd8, 32'h88);
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    for (int k = 1; k <= 6; k++) step();
    chk(3, 32'h0, "midclr q3");
    chk(8, 32'h88, "midclr q8");
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    clear_model();
    chk_all("midrst");
    chk(17, 32'd0, "midrst busy");
    chk(16, 32'd1, "midrst ready");
    do_write(4'd3, 32'h1234);
    chk(3, 32'h1234, "midrst wr3");

    // clr_req held high: ignored while clearing, restarts on the first IDLE edge
    bus.clr_req = 1'b1;
    step();
    chk(17, 32'd1, "held busy k0");
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 8)  chk(17, 32'd1, "held busy k8");
      if (k == 16) chk(17, 32'd0, "held busy k16");
    end
    step();
    chk(17, 32'd1, "held restart");
    bus.clr_req = 1'b0;
    for (int k = 1; k <= 16; k++) step();
    chk(17, 32'd0, "held second done");
    clear_model();
    chk_all("held end");

    // Hardwired entry 0
    chk(19, 32'd1, "z ready");
    bus_z.wr_valid = 1'b1;
    bus_z.wr_addr  = 4'd0;
    bus_z.wr_data  = 32'hFFFF_FFFF;
    step();
    bus_z.wr_valid = 1'b0;
    chk(18, 32'h0, "z q0");
    chk(19, 32'd1, "z ready after");
    bus_z.wr_valid = 1'b1;
    bus_z.wr_addr  = 4'd1;
    bus_z.wr_data  = 32'hCAFE;
    step();
    bus_z.wr_valid = 1'b0;
    chk(20, 32'hCAFE, "z q1");
    chk(18, 32'h0, "z q0 again");

    step();
    step();
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
